// File: rtl/lcd_line_ctrl.sv
// lcd_line_ctrl: two-line character buffer shown one line at a time on an HD44780 LCD.
// Optional button debounce is enabled with the macro LCD_BTN_DEBOUNCE_EN.
module lcd_line_ctrl #(
    parameter int CLK_DIV  = 5000,
    parameter int COLS     = 16,
    parameter int DB_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_line,
    input  logic [5:0] wr_col,
    input  logic [7:0] wr_char,
    input  logic       line_btn,
    output logic [7:0] lcd_data,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       cur_line,
    output logic       busy
);
    typedef enum logic [2:0] {PWR_WAIT, INIT, CLR_WAIT, ADDR, CHARS, IDLE} state_t;
    localparam int WW = $clog2((DB_TICKS > 200 ? DB_TICKS : 200) + 1);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int AW = $clog2(2 * COLS);
    localparam logic [5:0] NC = 6'(COLS);

    state_t          state;
    logic [1:0]      phase;
    logic [WW-1:0]   wait_cnt;
    logic [5:0]      idx;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [7:0]      mem [2*COLS];
    logic            wr_ok;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;
    logic [1:0]      sync;
    logic            db_lvl;
    logic            db_prev;
    logic            dirty;
    logic            pending;
    logic [7:0]      byte_out;
    logic            last;
    state_t          next;

    assign lcd_rw  = 1'b0;
    assign tick    = div_cnt == DW'(CLK_DIV - 1);
    assign wr_ok   = wr_en && wr_col < NC;
    assign wr_addr = AW'(int'(wr_line) * COLS + int'(wr_col));
    assign rd_addr = AW'(int'(cur_line) * COLS + int'(idx));

    // free-running tick divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_cnt <= '0;
        else     div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    // character buffer, writable at any time
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        for (int i = 0; i < 2 * COLS; i++) mem[i] <= 8'h20;
        else if (wr_ok) mem[wr_addr] <= wr_char;
    end

    // two-stage synchroniser for the asynchronous button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], line_btn};
    end

`ifdef LCD_BTN_DEBOUNCE_EN
    logic [WW-1:0] db_cnt;
    // level follows the synchronised button only after DB_TICKS differing ticks in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            db_lvl <= 1'b1;
        end else if (tick) begin
            if (sync[1] == db_lvl) db_cnt <= '0;
            else if (db_cnt == WW'(DB_TICKS - 1)) begin
                db_lvl <= sync[1];
                db_cnt <= '0;
            end else db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    assign db_lvl = sync[1];
`endif

    // byte source and sequencing for the byte-sending states
    always_comb begin
        byte_out = state == INIT ? (idx == 6'd0 ? 8'h38 : idx == 6'd1 ? 8'h0C : idx == 6'd2 ? 8'h06 : 8'h01)
                 : state == ADDR ? 8'h80 : mem[rd_addr];
        last     = state == INIT ? idx == 6'd3 : state == ADDR ? 1'b1 : idx == NC - 6'd1;
        next     = state == INIT ? CLR_WAIT : state == ADDR ? CHARS : IDLE;
    end

    // main sequencer with registered LCD outputs, dirty and toggle tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PWR_WAIT;
            phase    <= 2'd0;
            wait_cnt <= '0;
            idx      <= '0;
            lcd_data <= 8'h00;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            cur_line <= 1'b0;
            busy     <= 1'b1;
            dirty    <= 1'b0;
            pending  <= 1'b0;
            db_prev  <= 1'b1;
        end else begin
            db_prev <= db_lvl;
            if (wr_ok && wr_line == cur_line) dirty <= 1'b1;
            if (tick) begin
                case (state)
                    PWR_WAIT: begin
                        state    <= wait_cnt == WW'(199) ? INIT : PWR_WAIT;
                        wait_cnt <= wait_cnt == WW'(199) ? '0 : wait_cnt + 1'b1;
                    end
                    CLR_WAIT: begin
                        state    <= wait_cnt == WW'(19) ? ADDR : CLR_WAIT;
                        wait_cnt <= wait_cnt == WW'(19) ? '0 : wait_cnt + 1'b1;
                    end
                    IDLE: begin
                        if (pending) begin
                            cur_line <= ~cur_line;
                            pending  <= 1'b0;
                            dirty    <= 1'b0;
                            state    <= ADDR;
                            busy     <= 1'b1;
                        end else if (dirty) begin
                            dirty <= 1'b0;
                            state <= ADDR;
                            busy  <= 1'b1;
                        end
                    end
                    default: begin
                        if (phase == 2'd0) begin
                            lcd_data <= byte_out;
                            lcd_rs   <= state == CHARS;
                            phase    <= 2'd1;
                        end else if (phase == 2'd1) begin
                            lcd_en <= 1'b1;
                            phase  <= 2'd2;
                        end else begin
                            lcd_en <= 1'b0;
                            phase  <= 2'd0;
                            idx    <= last ? 6'd0 : idx + 6'd1;
                            if (last) begin
                                state <= next;
                                busy  <= state != CHARS;
                            end
                        end
                    end
                endcase
            end
            if (db_prev && !db_lvl) pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lcd_line_ctrl.sv
// tb_lcd_line_ctrl: directed self-checking bench for lcd_line_ctrl (CLK_DIV=4, COLS=16).
module tb_lcd_line_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_line = 1'b0;
    logic [5:0] wr_col = '0;
    logic [7:0] wr_char = '0;
    logic       line_btn = 1'b1;
    logic [7:0] lcd_data;
    logic       lcd_en, lcd_rs, lcd_rw, cur_line, busy;
    logic [8:0] q[$];
    int         checks = 0;
    int         errors = 0;

    lcd_line_ctrl #(.CLK_DIV(4), .COLS(16), .DB_TICKS(20)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col),
        .wr_char(wr_char), .line_btn(line_btn), .lcd_data(lcd_data), .lcd_en(lcd_en),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .cur_line(cur_line), .busy(busy)
    );

    always #5 clk = ~clk;

    // every E rising edge latches one {RS, DB} byte
    always @(posedge lcd_en) q.push_back({lcd_rs, lcd_data});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic l, input logic [5:0] c, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_line = l; wr_col = c; wr_char = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_busy(input logic v, input int lim, input string tag);
        int n = 0;
        while (busy !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'(v));
    endtask

    task automatic quiet(input int n, input string tag);
        int hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) hits++;
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_en", lcd_en, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_line", cur_line, 0);
        chk("rst_busy", busy, 1);

        q.delete();
        rst = 1'b0;
        n = 0;
        while (lcd_en !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("first_e_cycle", n, 808);
        wait_busy(1'b0, 3000, "init_done");
        chk("init_count", q.size(), 21);
        chk("init_0", q[0], 9'h038);
        chk("init_1", q[1], 9'h00C);
        chk("init_2", q[2], 9'h006);
        chk("init_3", q[3], 9'h001);
        chk("init_addr", q[4], 9'h080);
        for (int i = 5; i < 21; i++) chk("init_char", q[i], 9'h120);

        q.delete();
        wr(1'b0, 6'd3, 8'h41);
        wait_busy(1'b1, 20, "wrA_busy_rise");
        wait_busy(1'b0, 1000, "wrA_busy_fall");
        chk("wrA_count", q.size(), 17);
        chk("wrA_addr", q[0], 9'h080);
        chk("wrA_col2", q[3], 9'h120);
        chk("wrA_col3", q[4], 9'h141);

        q.delete();
        wr(1'b0, 6'd20, 8'h55);
        quiet(60, "col20_quiet");
        chk("col20_count", q.size(), 0);

        wr(1'b1, 6'd0, 8'h42);
        quiet(60, "hidden_quiet");
        chk("hidden_count", q.size(), 0);

        q.delete();
        line_btn = 1'b0;
        repeat (120) @(negedge clk);
        line_btn = 1'b1;
        wait_busy(1'b1, 400, "btn_busy_rise");
        wait_busy(1'b0, 1000, "btn_busy_fall");
        chk("btn_line", cur_line, 1);
        chk("btn_count", q.size(), 17);
        chk("btn_addr", q[0], 9'h080);
        chk("btn_col0", q[1], 9'h142);
        chk("btn_col4", q[5], 9'h120);
        repeat (100) @(negedge clk);

`ifdef LCD_BTN_DEBOUNCE_EN
        q.delete();
        line_btn = 1'b0;
        repeat (20) @(negedge clk);
        line_btn = 1'b1;
        quiet(200, "glitch_quiet");
        chk("glitch_line", cur_line, 1);
`endif

        q.delete();
        wr(1'b1, 6'd2, 8'h43);
        n = 0;
        while (q.size() < 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("chars_reached", q.size(), 3);
        wr(1'b1, 6'd7, 8'h44);
        repeat (1200) @(negedge clk);
        chk("midwr_count", q.size(), 34);
        chk("midwr_addr2", q[17], 9'h080);
        chk("midwr_col2", q[20], 9'h143);
        chk("midwr_col7", q[25], 9'h144);
        chk("midwr_idle", busy, 0);

        q.delete();
        wr(1'b1, 6'd0, 8'h45);
        n = 0;
        while (q.size() < 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_e", lcd_en, 1);
        chk("pulse_data", lcd_data, 8'h43);
        #1 rst = 1'b1;
        #1;
        chk("arst_en", lcd_en, 0);
        chk("arst_data", lcd_data, 8'h00);
        chk("arst_busy", busy, 1);
        chk("arst_line", cur_line, 0);
        @(negedge clk);
        q.delete();
        rst = 1'b0;
        wait_busy(1'b0, 3000, "reinit_done");
        chk("reinit_count", q.size(), 21);
        chk("reinit_0", q[0], 9'h038);
        chk("reinit_3", q[3], 9'h001);
        chk("reinit_addr", q[4], 9'h080);
        chk("reinit_col3", q[8], 9'h120);
        chk("final_rw", lcd_rw, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_line_ctrl.md
LCD_LINE_CTRL -- requirements
Module: lcd_line_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5000, meaning clk cycles per internal tick (10 kHz tick from 50 MHz).
REQ-002 SHALL have parameter COLS, default 16, meaning characters per display line; COLS <= 40.
REQ-003 SHALL have parameter DB_TICKS, default 20, meaning ticks for which the button must be stable to count as debounced.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is in this domain.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port wr_en, input, 1 bit: character-buffer write strobe, one clk cycle wide.
REQ-007 SHALL have port wr_line, input, 1 bit: buffer line selected for the write (0 = top, 1 = bottom).
REQ-008 SHALL have port wr_col, input, 6 bits: column selected for the write.
REQ-009 SHALL have port wr_char, input, 8 bits: ASCII code written.
REQ-010 SHALL have port line_btn, input, 1 bit: asynchronous, active-low push-button that toggles the displayed line.
REQ-011 SHALL have port lcd_data, output, 8 bits: HD44780 DB7..DB0.
REQ-012 SHALL have ports lcd_en, lcd_rs and lcd_rw, outputs, 1 bit each: HD44780 E, RS and R/W.
REQ-013 SHALL have port cur_line, output, 1 bit: buffer line currently shown.
REQ-014 SHALL have port busy, output, 1 bit: high in every FSM state except IDLE.

Function
REQ-015 SHALL advance the FSM only on tick; tick is a single-clk pulse once every CLK_DIV clk cycles, from a free-running counter.
REQ-016 SHALL hold a buffer of 2 x COLS bytes; wr_en writes in the same clk cycle regardless of busy; writes with wr_col >= COLS are ignored.
REQ-017 SHALL drive lcd_rw to 0 at all times; the block never reads the LCD.
REQ-018 SHALL send every byte in three ticks: SETUP (data and RS valid, E=0), PULSE (E=1), HOLD (E=0, data held).
REQ-019 SHALL step through these states: PWR_WAIT (200 ticks) -> INIT (bytes 0x38, 0x0C, 0x06, 0x01, RS=0) -> CLR_WAIT (20 ticks) -> ADDR -> CHARS -> IDLE.
REQ-020 In ADDR, SHALL send command 0x80, RS=0, so text is always written to physical row 0.
REQ-021 In CHARS, SHALL send buffer[cur_line][0..COLS-1] in order with RS=1, then go to IDLE.
REQ-022 SHALL set a dirty flag on any accepted write to line cur_line, including a write made during ADDR or CHARS.
REQ-023 In IDLE, SHALL service a pending toggle first: invert cur_line, clear toggle-pending and dirty, go to ADDR.
REQ-024 In IDLE with no toggle pending and dirty set, SHALL clear dirty and go to ADDR.
REQ-025 SHALL synchronise line_btn through 2 flip-flops; a debounced high-to-low transition sets toggle-pending.
REQ-026 SHALL count further presses while toggle-pending is already set as a single press; pending is not a counter.
REQ-027 SHALL ignore writes to the line not currently shown for dirty purposes; that line is displayed on the next toggle.

Reset
REQ-028 On rst, SHALL set: lcd_data=0x00, lcd_en=0, lcd_rs=0, lcd_rw=0, cur_line=0, busy=1, state=PWR_WAIT.
REQ-029 On rst, SHALL clear all counters, dirty and toggle-pending, and fill the buffer with 0x20.
REQ-030 On rst mid-byte or mid-sequence, SHALL abort immediately; after release, the full PWR_WAIT/INIT sequence restarts.

Configuration
REQ-031 With macro LCD_BTN_DEBOUNCE_EN defined, the synchronised button SHALL be stable for DB_TICKS consecutive ticks before its debounced level changes.
REQ-032 Without LCD_BTN_DEBOUNCE_EN, the debounced level SHALL equal the synchronised level, with no debounce counter instantiated.

Verification
REQ-033 Release rst with CLK_DIV=4 -> after 200 ticks: E pulses with 0x38, 0x0C, 0x06, 0x01; 20 ticks later 0x80 then sixteen 0x20 with RS=1; busy falls.
REQ-034 In IDLE, write 'A' (0x41) to line 0, col 3 -> 0x80 resent, 4th RS=1 byte is 0x41, busy returns low.
REQ-035 Press line_btn low for 30 ticks (debounce on) -> cur_line=1, line-1 contents are sent; a 5-tick glitch produces no toggle.
REQ-036 Write to line 0 during CHARS -> after IDLE the line is refreshed exactly once more with the new byte.
REQ-037 Assert rst during PULSE of the 3rd CHARS byte -> lcd_en=0 and lcd_data=0 asynchronously; full init repeats.
REQ-038 Write with wr_col=20 (COLS=16) -> no buffer change, dirty stays 0, busy stays low.
